// File: rtl/ifetch_pq_pkg.sv
// Shared defaults and in-flight entry layout for the prefetching fetch unit.
// Each in-flight entry is packed as {valid, addr}.
package ifetch_pq_pkg;

   localparam int          ADDR_DEF     = 16;
   localparam int          WORD_DEF     = 32;
   localparam int          DEPTH_DEF    = 4;
   localparam int          MEM_LAT_DEF  = 1;
   localparam int unsigned RESET_PC_DEF = 0;

   localparam int FL_ADDR_LSB = 0;

   function automatic int fl_valid_bit(input int addr_w);
      return FL_ADDR_LSB + addr_w;
   endfunction

   function automatic int fl_width(input int addr_w);
      return addr_w + 1;
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ifetch_pq_if.sv
// Fetch-unit bus: the instruction-memory read port plus the decode handshake.
// The fetch unit takes the master side.
interface ifetch_pq_if #(
   parameter int ADDR = 16,
   parameter int WORD = 32
);

   logic            en_i;
   logic            stall_i;
   logic            branch_i;
   logic [ADDR-1:0] baddr_i;
   logic [ADDR-1:0] mem_addr_o;
   logic            mem_rd_o;
   logic [WORD-1:0] mem_q_i;
   logic            v_o;
   logic [WORD-1:0] inst_o;
   logic [ADDR-1:0] pc_o;

   modport master (
      input  en_i, stall_i, branch_i, baddr_i, mem_q_i,
      output mem_addr_o, mem_rd_o, v_o, inst_o, pc_o
   );

   modport slave (
      output en_i, stall_i, branch_i, baddr_i, mem_q_i,
      input  mem_addr_o, mem_rd_o, v_o, inst_o, pc_o
   );

endinterface

// File: rtl/ifetch_pq_fifo.sv
// WIDTH x DEPTH synchronous FIFO with flush; the head is a registered entry,
// so a word written on one edge is visible on head_o the following cycle.
module ifetch_fifo
   import ifetch_pq_pkg::*;
#(
   parameter  int WIDTH = 48,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [CW-1:0]    count_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Explicit wrap so non-power-of-two depths work too.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop_i && (count_q != '0) && !flush_i;
      do_push  = push_i && !flush_i && ((count_q != CW'(DEPTH)) || do_pop);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_pq.sv
// Instruction fetch with a prefetch queue: issues sequential word reads, tracks
// them through a MEM_LAT-deep in-flight pipe, and queues returns for decode.
module ifetch_pq
   import ifetch_pq_pkg::*;
#(
   parameter int          ADDR     = ADDR_DEF,
   parameter int          WORD     = WORD_DEF,
   parameter int          DEPTH    = DEPTH_DEF,
   parameter int          MEM_LAT  = MEM_LAT_DEF,
   parameter int unsigned RESET_PC = RESET_PC_DEF
) (
   input logic         clk,
   input logic         rst,
   ifetch_pq_if.master bus
);

   localparam int FLW = fl_width(ADDR);
   localparam int VB  = fl_valid_bit(ADDR);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int IW  = $clog2(MEM_LAT + 1);

   logic [ADDR-1:0]      pc_q, pc_d;
   logic [FLW-1:0]       pipe_q [MEM_LAT];
   logic [FLW-1:0]       pipe_d [MEM_LAT];
   logic [FLW-1:0]       last;
   logic [IW-1:0]        inflight;
   logic [CW-1:0]        count;
   logic [ADDR+WORD-1:0] head;
   logic [ADDR-1:0]      addr_sel;
   logic                 issue, v, push, pop;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LAT; i++) inflight = inflight + IW'(pipe_q[i][VB]);
   end

   // Issue is throttled on queued plus outstanding reads, so the queue can never overflow.
   assign addr_sel = bus.branch_i ? bus.baddr_i : pc_q;
   assign issue    = bus.en_i && (bus.branch_i || ((int'(count) + int'(inflight)) < DEPTH));

   always_comb begin
      pc_d = issue ? addr_sel + ADDR'(1) : addr_sel;
   end

   // A redirect kills every read already in flight, including one returning now.
   always_comb begin
      pipe_d[0] = {issue, addr_sel};
      for (int i = 1; i < MEM_LAT; i++) begin
         pipe_d[i]     = pipe_q[i-1];
         pipe_d[i][VB] = pipe_q[i-1][VB] && !bus.branch_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= ADDR'(RESET_PC);
         for (int i = 0; i < MEM_LAT; i++) pipe_q[i] <= '0;
      end else begin
         pc_q   <= pc_d;
         pipe_q <= pipe_d;
      end
   end

   assign last = pipe_q[MEM_LAT-1];
   assign push = last[VB] && !bus.branch_i;
   assign v    = (count != '0);
   assign pop  = v && !bus.stall_i && !bus.branch_i;

   ifetch_fifo #(
      .WIDTH (ADDR + WORD),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (bus.branch_i),
      .din_i   ({last[ADDR-1:0], bus.mem_q_i}),
      .count_o (count),
      .head_o  (head)
   );

   assign bus.mem_addr_o = addr_sel;
   assign bus.mem_rd_o   = issue;
   assign bus.v_o        = v;
   assign bus.inst_o     = v ? head[WORD-1:0] : '0;
   assign bus.pc_o       = v ? head[ADDR+WORD-1:WORD] : '0;

endmodule
